// File: rtl/sonar_tx_sequenciador.sv
// rtl/sonar_tx_sequenciador.sv - sonar frame sequencer feeding the UART TX one ASCII char at a time
//
// Ports:
//   clock, reset          : system clock (rising edge), asynchronous active-high reset
//   partida               : start-of-frame pulse, only honoured in INICIAL
//   angulo, distancia     : 3 BCD digits each ([11:8] hundreds, [7:4] tens, [3:0] units)
//   serial_pronto         : UART pulse, current character fully sent
//   serial_partida        : 1-cycle pulse telling the UART to load serial_dado
//   serial_dado           : ASCII character at the current index (0 in INICIAL)
//   ocupado               : high from CARREGA through FIM
//   pronto                : 1-cycle pulse on successful frame completion
//   erro_timeout          : sticky watchdog abort flag
//   db_estado, db_indice  : debug view of state and character index
//
// Frame: a2 a1 a0 ',' d2 d1 d0 '#'.
// Optional macro SONAR_TX_CHECKSUM_EN appends a 9th checksum character.
module sonar_tx_sequenciador #(
  parameter int TIMEOUT_CICLOS = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [11:0] angulo,
  input  logic [11:0] distancia,
  input  logic        serial_pronto,
  output logic        serial_partida,
  output logic [6:0]  serial_dado,
  output logic        ocupado,
  output logic        pronto,
  output logic        erro_timeout,
  output logic [3:0]  db_estado,
  output logic [3:0]  db_indice
);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    CARREGA = 4'd1,
    ENVIA   = 4'd2,
    ESPERA  = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5,
    ERRO    = 4'd6
  } estado_t;

`ifdef SONAR_TX_CHECKSUM_EN
  localparam logic [3:0] ULTIMO = 4'd8;
`else
  localparam logic [3:0] ULTIMO = 4'd7;
`endif

  localparam int CW = $clog2(TIMEOUT_CICLOS);
  localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CICLOS - 1);

  estado_t       estado, proximo;
  logic [11:0]   ang_q, dist_q;
  logic [3:0]    indice;
  logic [CW-1:0] contador;
  logic          erro_q;
  logic [6:0]    caractere;
  logic          fim_contagem;

  function automatic logic [6:0] digito(input logic [3:0] n);
    return (n > 4'd9) ? 7'h3F : (7'h30 + {3'b000, n});
  endfunction

`ifdef SONAR_TX_CHECKSUM_EN
  logic [6:0] soma_xor;
  assign soma_xor = digito(ang_q[11:8]) ^ digito(ang_q[7:4]) ^ digito(ang_q[3:0]) ^ 7'h2C ^
                    digito(dist_q[11:8]) ^ digito(dist_q[7:4]) ^ digito(dist_q[3:0]) ^ 7'h23;
`endif

  always_comb begin
    caractere = 7'h00;
    case (indice)
      4'd0: caractere = digito(ang_q[11:8]);
      4'd1: caractere = digito(ang_q[7:4]);
      4'd2: caractere = digito(ang_q[3:0]);
      4'd3: caractere = 7'h2C;
      4'd4: caractere = digito(dist_q[11:8]);
      4'd5: caractere = digito(dist_q[7:4]);
      4'd6: caractere = digito(dist_q[3:0]);
      4'd7: caractere = 7'h23;
`ifdef SONAR_TX_CHECKSUM_EN
      4'd8: caractere = {1'b1, soma_xor[5:0]};
`endif
      default: caractere = 7'h00;
    endcase
  end

  // Watchdog terminal count; a simultaneous serial_pronto takes priority.
  assign fim_contagem = (contador == TERMINAL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo;
  end

  always_comb begin
    proximo        = estado;
    serial_partida = 1'b0;
    ocupado        = 1'b0;
    pronto         = 1'b0;
    case (estado)
      INICIAL: if (partida) proximo = CARREGA;
      CARREGA: begin
        ocupado = 1'b1;
        proximo = ENVIA;
      end
      ENVIA: begin
        ocupado        = 1'b1;
        serial_partida = 1'b1;
        proximo        = ESPERA;
      end
      ESPERA: begin
        ocupado = 1'b1;
        if (serial_pronto)     proximo = PROXIMO;
        else if (fim_contagem) proximo = ERRO;
      end
      PROXIMO: begin
        ocupado = 1'b1;
        proximo = (indice == ULTIMO) ? FIM : ENVIA;
      end
      FIM: begin
        ocupado = 1'b1;
        pronto  = 1'b1;
        proximo = INICIAL;
      end
      ERRO:    proximo = INICIAL;
      default: proximo = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ang_q    <= 12'h000;
      dist_q   <= 12'h000;
      indice   <= 4'd0;
      contador <= '0;
      erro_q   <= 1'b0;
    end else begin
      case (estado)
        INICIAL: if (partida) begin
          ang_q  <= angulo;
          dist_q <= distancia;
          indice <= 4'd0;
          erro_q <= 1'b0;
        end
        ENVIA:  contador <= '0;
        ESPERA: begin
          contador <= contador + 1'b1;
          if (!serial_pronto && fim_contagem) erro_q <= 1'b1;
        end
        PROXIMO: if (indice != ULTIMO) indice <= indice + 4'd1;
        default: ;
      endcase
    end
  end

  assign serial_dado  = (estado == INICIAL) ? 7'h00 : caractere;
  assign erro_timeout = erro_q;
  assign db_estado    = estado;
  assign db_indice    = indice;

endmodule

// File: tb/tb_sonar_tx_sequenciador.sv
// tb/tb_sonar_tx_sequenciador.sv - scoreboard bench for sonar_tx_sequenciador
module tb_sonar_tx_sequenciador;

  localparam int T = 50;

  logic        clock = 1'b0;
  logic        reset, partida, serial_pronto;
  logic [11:0] angulo, distancia;
  logic        serial_partida, ocupado, pronto, erro_timeout;
  logic [6:0]  serial_dado;
  logic [3:0]  db_estado, db_indice;

  sonar_tx_sequenciador #(.TIMEOUT_CICLOS(T)) dut (
    .clock(clock), .reset(reset), .partida(partida), .angulo(angulo),
    .distancia(distancia), .serial_pronto(serial_pronto),
    .serial_partida(serial_partida), .serial_dado(serial_dado),
    .ocupado(ocupado), .pronto(pronto), .erro_timeout(erro_timeout),
    .db_estado(db_estado), .db_indice(db_indice)
  );

  always #5 clock = ~clock;

  typedef struct {int idx; int ch;} exp_t;
  exp_t exp_q[$];
  exp_t e;

  int checks = 0, failures = 0;
  int pronto_cnt = 0, cyc = 0;
  int mute = 0, term_once = 0, fixed_delay = 0;
  logic [6:0] last_dado = 7'h00;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    end
  endtask

  function automatic int dig(input int n);
    return (n > 9) ? 63 : 48 + n;
  endfunction

  task automatic push_frame(input int a, input int d);
    int c[9];
    int n;
    c[0] = dig((a >> 8) & 15); c[1] = dig((a >> 4) & 15); c[2] = dig(a & 15); c[3] = 44;
    c[4] = dig((d >> 8) & 15); c[5] = dig((d >> 4) & 15); c[6] = dig(d & 15); c[7] = 35;
    n = 8;
`ifdef SONAR_TX_CHECKSUM_EN
    c[8] = 0;
    for (int i = 0; i < 8; i++) c[8] = c[8] ^ c[i];
    c[8] = (c[8] & 63) | 64;
    n = 9;
`endif
    for (int i = 0; i < n; i++) exp_q.push_back('{idx: i, ch: c[i]});
  endtask

  always @(posedge clock) cyc++;

  // Monitor: pops the scoreboard on every serial_partida.
  always @(negedge clock) begin
    if (!reset) begin
      if (serial_partida) begin
        if (exp_q.size() == 0) chk("char_inesperado", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("serial_dado", 32'(serial_dado), e.ch);
          chk("db_indice", 32'(db_indice), e.idx);
        end
        last_dado = serial_dado;
      end else if (db_estado == 4'd3) begin
        chk("dado_estavel", 32'(serial_dado), 32'(last_dado));
      end
      if (pronto) pronto_cnt++;
      chk("ocupado", 32'(ocupado), 32'(db_estado >= 4'd1 && db_estado <= 4'd5));
    end
  end

  // UART model.
  initial begin
    int d;
    serial_pronto = 1'b0;
    forever begin
      @(negedge clock);
      if (serial_partida && mute == 0 && !reset) begin
        if (term_once != 0) d = T;
        else if (fixed_delay != 0) d = fixed_delay;
        else d = int'($urandom_range(1, 8));
        term_once = 0;
        repeat (d) @(posedge clock);
        #1 serial_pronto = 1'b1;
        @(posedge clock);
        #1 serial_pronto = 1'b0;
      end
    end
  end

  task automatic pulse(input logic [11:0] a, input logic [11:0] d);
    @(negedge clock);
    angulo = a; distancia = d; partida = 1'b1;
    @(posedge clock);
    #1 partida = 1'b0;
  endtask

  task automatic wait_inicial();
    int n = 0;
    while (db_estado != 4'd0 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk("fim_quadro_limite", 32'(n < 5000), 1);
  endtask

  task automatic run_frame(input logic [11:0] a, input logic [11:0] d);
    int p0 = pronto_cnt;
    push_frame(int'(a), int'(d));
    pulse(a, d);
    chk("erro_limpo", 32'(erro_timeout), 0);
    angulo = 12'($urandom); distancia = 12'($urandom);
    wait_inicial();
    chk("pronto_unico", pronto_cnt - p0, 1);
    chk("fila_vazia", exp_q.size(), 0);
    chk("sem_erro", 32'(erro_timeout), 0);
  endtask

  initial begin
    int p0, c_env, n;
    reset = 1'b1; partida = 1'b0; angulo = 12'h0; distancia = 12'h0;
    #1;
    chk("rst_serial_partida", 32'(serial_partida), 0);
    chk("rst_serial_dado", 32'(serial_dado), 0);
    chk("rst_ocupado", 32'(ocupado), 0);
    chk("rst_pronto", 32'(pronto), 0);
    chk("rst_erro", 32'(erro_timeout), 0);
    chk("rst_estado", 32'(db_estado), 0);
    chk("rst_indice", 32'(db_indice), 0);
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b0;

    // Directed frame with latency check.
    fixed_delay = 5;
    p0 = pronto_cnt;
    push_frame(12'h045, 12'h123);
    pulse(12'h045, 12'h123);
    chk("lat_carrega_sp", 32'(serial_partida), 0);
    chk("lat_carrega_est", 32'(db_estado), 1);
    @(posedge clock); #1;
    chk("lat_envia_sp", 32'(serial_partida), 1);
    wait_inicial();
    chk("dir_pronto", pronto_cnt - p0, 1);
    chk("dir_fila", exp_q.size(), 0);
    chk("dir_erro", 32'(erro_timeout), 0);
    fixed_delay = 0;

    run_frame(12'h0A9, 12'h987);

    for (int k = 0; k < 12; k++)
      run_frame({4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 15))},
                {4'($urandom_range(0, 15)), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))});

    // Watchdog abort.
    mute = 1;
    p0 = pronto_cnt;
    exp_q.push_back('{idx: 0, ch: dig(3)});
    pulse(12'h321, 12'h456);
    n = 0;
    while (!serial_partida && n < 100) begin @(negedge clock); n++; end
    c_env = cyc;
    n = 0;
    while (db_estado != 4'd6 && n < 200) begin @(negedge clock); n++; end
    chk("erro_latencia", cyc - c_env, T + 1);
    chk("erro_flag", 32'(erro_timeout), 1);
    chk("erro_sem_pronto", 32'(pronto), 0);
    wait_inicial();
    chk("erro_sticky", 32'(erro_timeout), 1);
    chk("erro_pronto_cnt", pronto_cnt - p0, 0);
    chk("erro_fila", exp_q.size(), 0);
    mute = 0;
    run_frame(12'h111, 12'h222);

    // serial_pronto on the terminal count cycle.
    term_once = 1;
    run_frame(12'h789, 12'h012);

    // Second partida during char 3 is ignored.
    p0 = pronto_cnt;
    push_frame(12'h135, 12'h246);
    pulse(12'h135, 12'h246);
    n = 0;
    while (!(serial_partida && db_indice == 4'd3) && n < 500) begin @(negedge clock); n++; end
    angulo = 12'h999; distancia = 12'h888; partida = 1'b1;
    @(posedge clock); #1 partida = 1'b0;
    wait_inicial();
    chk("ign_pronto", pronto_cnt - p0, 1);
    chk("ign_fila", exp_q.size(), 0);

    // Reset in ESPERA of char 4.
    fixed_delay = 8;
    p0 = pronto_cnt;
    push_frame(12'h864, 12'h975);
    pulse(12'h864, 12'h975);
    n = 0;
    while (!(db_estado == 4'd3 && db_indice == 4'd4) && n < 500) begin @(negedge clock); n++; end
    @(posedge clock); #1 reset = 1'b1;
    #1;
    exp_q.delete();
    chk("rst_mid_estado", 32'(db_estado), 0);
    chk("rst_mid_dado", 32'(serial_dado), 0);
    chk("rst_mid_ocupado", 32'(ocupado), 0);
    chk("rst_mid_indice", 32'(db_indice), 0);
    chk("rst_mid_erro", 32'(erro_timeout), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (15) @(negedge clock);
    chk("rst_mid_pronto", pronto_cnt - p0, 0);
    fixed_delay = 0;
    run_frame(12'h505, 12'h606);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not end");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
